// File: rtl/rev_serial_16b.sv
// Serial bit-reverser: accepts a word, then either passes it through or
// reverses it one bit per clock, and holds the result until it is taken.
module rev_serial_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             revBit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_rev;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  // A pass-through word never shifts, so r_rev also guards the exit.
  assign w_last   = (r_cnt == CNT_LAST) || !r_rev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = revBit ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src <= '0;
      r_out <= '0;
      r_cnt <= '0;
      r_rev <= 1'b0;
    end else if (w_accept) begin
      r_src <= in;
      r_rev <= revBit;
      r_cnt <= '0;
      r_out <= revBit ? '0 : in;
    end else if (r_state == S_SHIFT) begin
      r_out <= {r_out[WIDTH-2:0], r_src[0]};
      r_src <= r_src >> 1;
      // Saturate on the final shift so the count never wraps.
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out       = r_out;

endmodule

// File: tb/tb_rev_serial_16b.sv
// Bench for rev_serial_16b: vector table, corner-case sequences,
// and a queue scoreboard watching every handoff.
module tb_rev_serial_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in = '0;
  logic        revBit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  rev_serial_16b #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in(in), .revBit(revBit),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;
  int n_push = 0;
  int n_pop = 0;
  int n_abort = 0;
  logic [15:0] sbq[$];

  typedef struct {
    logic [15:0] din;
    logic        rev;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [15:0] brev(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n_abort += sbq.size();
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          n_pop++;
          chk("sb_data", 32'(out), 32'(sbq.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(revBit ? brev(in) : in);
        n_push++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic run_word(input logic [15:0] d, input logic r,
                          output logic [15:0] got, output int cyc);
    @(posedge clk); #1;
    in = d; revBit = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in = 16'($urandom); revBit = 1'($urandom);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    got = out;
  endtask

  vec_t        vecs[8];
  logic [15:0] got;
  int          cyc;
  bit          seen;
  bit          done;

  initial begin
    vecs[0] = '{16'h0001, 1'b1, 16'h8000, 17};
    vecs[1] = '{16'hA5C3, 1'b0, 16'hA5C3, 1};
    vecs[2] = '{16'hA5C3, 1'b1, 16'hC3A5, 17};
    vecs[3] = '{16'h1234, 1'b1, 16'h2C48, 17};
    vecs[4] = '{16'hFFFF, 1'b1, 16'hFFFF, 17};
    vecs[5] = '{16'h0000, 1'b1, 16'h0000, 17};
    vecs[6] = '{16'h8000, 1'b1, 16'h0001, 17};
    vecs[7] = '{16'hF0F0, 1'b0, 16'hF0F0, 1};

    #2;
    chk("reset_state", {13'b0, busy, out_valid, in_ready, out},
        {13'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      run_word(vecs[i].din, vecs[i].rev, got, cyc);
      chk($sformatf("vec%0d_lat", i), 32'(cyc), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_out", i), 32'(got), 32'(vecs[i].exp));
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
    end

    out_ready = 1'b0;
    run_word(16'h1234, 1'b1, got, cyc);
    chk("hold_lat", 32'(cyc), 32'd17);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = 1'(k & 1); in = 16'($urandom); revBit = 1'b1;
      @(negedge clk);
      chk($sformatf("hold_c%0d", k),
          {13'b0, busy, out_valid, in_ready, out},
          {13'b0, 1'b1, 1'b1, 1'b0, 16'h2C48});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_release", {15'b0, in_ready, out}, {15'b0, 1'b1, 16'h2C48});

    @(posedge clk); #1;
    in = 16'h3C5A; revBit = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in = 16'h0F1E;
    @(negedge clk);
    chk("sim_first", {15'b0, out_valid, out}, {15'b0, 1'b1, 16'h3C5A});
    @(negedge clk);
    chk("sim_no_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("sim_second", {15'b0, out_valid, out}, {15'b0, 1'b1, 16'h0F1E});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);

    @(posedge clk); #1;
    in = 16'hFFFF; revBit = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in = 16'h0000;
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_lat1", 32'(cyc), 32'd17);
    chk("b2b_out1", 32'(out), 32'h0000_FFFF);
    @(negedge clk); cyc++;
    chk("b2b_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); cyc++;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_lat2", 32'(cyc), 32'd35);
    chk("b2b_out2", 32'(out), 32'h0000_0000);
    @(negedge clk);

    @(posedge clk); #1;
    in = 16'h00FF; revBit = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_now", {13'b0, busy, out_valid, in_ready, out},
        {13'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_word(16'h5A5A, 1'b0, got, cyc);
    chk("post_rst_lat", 32'(cyc), 32'd1);
    chk("post_rst_out", 32'(got), 32'h0000_5A5A);
    @(negedge clk);

    done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int t;
          in = 16'($urandom); revBit = 1'($urandom); in_valid = 1'b1;
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!in_ready && t < 500);
          chk("rnd_accept", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 200 && !(sbq.size() == 0 && in_ready); t++)
      @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    chk("sb_balance", 32'(n_push), 32'(n_pop + n_abort));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rev_serial_16b.md
REV_SERIAL_16B -- requirements
Module: rev_serial_16b

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL be a power of two >= 2.
REQ-002 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in  input  WIDTH  source word; sampled only on the accept edge.
REQ-005 revBit  input  1  mode, sampled with in: 1 = bit-reverse, 0 = pass-through.
REQ-006 in_valid  input  1  producer offers in/revBit.
REQ-007 in_ready  output  1  block can accept a word; SHALL be high only in IDLE.
REQ-008 out  output  WIDTH  result word; SHALL hold its value while out_valid is high.
REQ-009 out_valid  output  1  result available; SHALL be high only in DONE.
REQ-010 out_ready  input  1  consumer takes out.
REQ-011 busy  output  1  SHALL be high in SHIFT and DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 Accept: in IDLE with in_valid=1 at a rising edge, latch in into src register, latch revBit, clear counter.
REQ-014 On accept with revBit=0: load out <= in and go to DONE (out_valid high 1 cycle after accept edge).
REQ-015 On accept with revBit=1: clear out and go to SHIFT.
REQ-016 Each SHIFT cycle: out <= {out[WIDTH-2:0], src[0]}; src <= src >> 1; counter += 1.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the edge where counter = WIDTH-1 the final shift occurs and the FSM goes to DONE.
REQ-018 revBit=1 latency: out_valid high WIDTH+1 cycles after the accept edge (17 for WIDTH=16); out[i] = original in[WIDTH-1-i] for all i.
REQ-019 Counter width SHALL be log2(WIDTH) bits; it SHALL NOT wrap during a valid operation.
REQ-020 DONE: out_valid=1; when out_ready=1 at a rising edge, go to IDLE; otherwise hold out and stay in DONE indefinitely.
REQ-021 in_valid outside IDLE SHALL be ignored; in/revBit changes outside the accept edge SHALL NOT affect out.
REQ-022 In DONE with out_ready=1 and in_valid=1 simultaneously, the new word SHALL NOT be accepted that edge; it is accepted on the following edge (IDLE).
REQ-023 out SHALL retain its last value in IDLE after the handoff until the next load.
REQ-024 Throughput: one word per WIDTH+2 cycles (revBit=1) or per 2 cycles (revBit=0) with out_ready held high.

Reset
REQ-025 rst=1 SHALL immediately (without clk) force state IDLE, out=0, src=0, counter=0, revBit latch=0, out_valid=0, busy=0, in_ready=1.
REQ-026 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no out_valid pulse SHALL follow deassertion.
REQ-027 Following rst deassertion, the first rising edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-028 in=16'h0001, revBit=1, out_ready=1 -> out_valid at cycle 17 after accept, out=16'h8000, then in_ready=1 next cycle.
REQ-029 in=16'hA5C3, revBit=0 -> out_valid 1 cycle after accept, out=16'hA5C3; in=16'hA5C3, revBit=1 -> out=16'hC3A5.
REQ-030 in=16'h1234, revBit=1, out_ready=0 for 10 cycles after out_valid -> out=16'h2C48 stable, busy=1, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-031 in=16'hFFFF then 16'h0000 back-to-back, revBit=1 -> outputs 16'hFFFF then 16'h0000, second accepted exactly one cycle after first handoff.
REQ-032 rst pulsed at SHIFT cycle 8 of in=16'h00FF -> out=0, out_valid=0, in_ready=1 immediately; no result produced.
REQ-033 Random in/revBit for >=200 words with random out_ready -> every out equals bit-reverse(in) or in per revBit; no lost or duplicated words.
